// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: sweep FSM states,
// default potential/weight widths and a signed saturating adder.
package snn_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        SWEEP = 1'b1
    } lif_state_e;

    localparam int DEFAULT_POT_W = 16;
    localparam int DEFAULT_WGT_W = 16;

    // Operands arrive sign-extended to 64 bits; the result is clamped to the
    // signed range of a 'width'-bit word so callers can truncate it safely.
    function automatic longint sat_add(
        input longint a,
        input longint b,
        input int     width
    );
        longint sum;
        longint max_v;
        longint min_v;
        sum   = a + b;
        max_v = (longint'(1) <<< (width - 1)) - 1;
        min_v = -max_v - 1;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational evaluation of one leaky integrate-and-fire neuron: applies
// refractory countdown, threshold/fire and leak to produce its next state.
module lif_update_core #(
    parameter int POT_W        = 16,
    parameter int REF_W        = 8,
    parameter int LEAK_SHIFT   = 4,
    parameter int REFRAC_TICKS = 2
) (
    input  logic signed [POT_W-1:0] pot,
    input  logic        [REF_W-1:0] refrac,
    input  logic signed [POT_W-1:0] threshold,
    output logic signed [POT_W-1:0] pot_nxt,
    output logic        [REF_W-1:0] refrac_nxt,
    output logic                    fire
);

    logic signed [POT_W-1:0] leaked;

    always_comb begin
        // Arithmetic shift makes negative potentials decay toward zero as well.
        if (LEAK_SHIFT == 0) begin
            leaked = pot;
        end else begin
            leaked = pot - (pot >>> LEAK_SHIFT);
        end
    end

    always_comb begin
        pot_nxt    = leaked;
        refrac_nxt = refrac;
        fire       = 1'b0;
        if (refrac != '0) begin
            refrac_nxt = refrac - REF_W'(1);
            pot_nxt    = '0;
        end else if (pot >= threshold) begin
            fire       = 1'b1;
            pot_nxt    = '0;
            refrac_nxt = REF_W'(REFRAC_TICKS);
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one update
// core. Optional spike statistics ports are enabled by LIF_SPIKE_COUNT_EN.
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int IDX_W        = $clog2(N_NEURONS),
    parameter int POT_W        = DEFAULT_POT_W,
    parameter int WGT_W        = DEFAULT_WGT_W,
    parameter int LEAK_SHIFT   = 4,
    parameter int REFRAC_TICKS = 2,
    parameter int REF_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [POT_W-1:0] threshold,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [IDX_W-1:0] in_idx,
    input  logic signed [WGT_W-1:0] in_weight,
    input  logic                    tick,
    output logic                    busy,
    output logic                    spk_valid,
    output logic        [IDX_W-1:0] spk_idx,
    output logic                    sweep_done
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic        [15:0]      spike_total,
    output logic        [IDX_W:0]   last_sweep_spikes
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic signed [POT_W-1:0] pot_q [N_NEURONS];
    logic signed [POT_W-1:0] pot_d [N_NEURONS];
    logic [REF_W-1:0] refrac_q [N_NEURONS];
    logic [REF_W-1:0] refrac_d [N_NEURONS];
    logic spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0] spk_idx_q, spk_idx_d;
    logic sweep_done_q, sweep_done_d;

    logic signed [POT_W-1:0] core_pot;
    logic        [REF_W-1:0] core_refrac;
    logic                    core_fire;
    logic                    in_range;
    logic                    eval_en;
    logic signed [POT_W-1:0] acc_sum;

    lif_update_core #(
        .POT_W        (POT_W),
        .REF_W        (REF_W),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_TICKS (REFRAC_TICKS)
    ) u_core (
        .pot        (pot_q[ptr_q]),
        .refrac     (refrac_q[ptr_q]),
        .threshold  (threshold),
        .pot_nxt    (core_pot),
        .refrac_nxt (core_refrac),
        .fire       (core_fire)
    );

    assign in_range = ({1'b0, in_idx} < (IDX_W + 1)'(N_NEURONS));
    assign acc_sum  = POT_W'(sat_add(longint'(pot_q[in_idx]), longint'(in_weight), POT_W));
    assign eval_en  = en && (state_q == SWEEP);

    assign in_ready   = en && (state_q == ACCUM);
    assign busy       = (state_q == SWEEP);
    assign spk_idx    = spk_idx_q;
    // Registered outputs are masked, not cleared, so a pending pulse survives a freeze.
    assign spk_valid  = en && spk_valid_q;
    assign sweep_done = en && sweep_done_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        ptr_d        = ptr_q;
        pot_d        = pot_q;
        refrac_d     = refrac_q;
        spk_valid_d  = spk_valid_q;
        spk_idx_d    = spk_idx_q;
        sweep_done_d = sweep_done_q;
        if (en) begin
            spk_valid_d  = 1'b0;
            sweep_done_d = 1'b0;
            case (state_q)
                ACCUM: begin
                    if (in_valid && in_range && (refrac_q[in_idx] == '0)) begin
                        pot_d[in_idx] = acc_sum;
                    end
                    if (tick) begin
                        state_d = SWEEP;
                        ptr_d   = '0;
                    end
                end
                SWEEP: begin
                    pot_d[ptr_q]    = core_pot;
                    refrac_d[ptr_q] = core_refrac;
                    spk_valid_d     = core_fire;
                    if (core_fire) begin
                        spk_idx_d = ptr_q;
                    end
                    if (ptr_q == LAST_IDX) begin
                        state_d      = ACCUM;
                        ptr_d        = '0;
                        sweep_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            ptr_q        <= '0;
            spk_valid_q  <= 1'b0;
            spk_idx_q    <= '0;
            sweep_done_q <= 1'b0;
            // NOTE: the per-neuron arrays are plain registers, so they are reset like any other flop.
            for (int i = 0; i < N_NEURONS; i++) begin
                pot_q[i]    <= '0;
                refrac_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep all state updates on the same clock edge.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            spk_valid_q  <= spk_valid_d;
            spk_idx_q    <= spk_idx_d;
            sweep_done_q <= sweep_done_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                pot_q[i]    <= pot_d[i];
                refrac_q[i] <= refrac_d[i];
            end
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]  total_q, total_d;
    logic [IDX_W:0] sweep_cnt_q, sweep_cnt_d;
    logic [IDX_W:0] last_q, last_d;

    assign spike_total       = total_q;
    assign last_sweep_spikes = last_q;

    always_comb begin
        total_d     = total_q;
        sweep_cnt_d = sweep_cnt_q;
        last_d      = last_q;
        if (eval_en) begin
            if (core_fire) begin
                if (total_q != 16'hFFFF) begin
                    total_d = total_q + 16'd1;
                end
                sweep_cnt_d = sweep_cnt_q + (IDX_W + 1)'(1);
            end
            if (ptr_q == LAST_IDX) begin
                last_d      = sweep_cnt_q + (IDX_W + 1)'(core_fire);
                sweep_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q     <= '0;
            sweep_cnt_q <= '0;
            last_q      <= '0;
        end else begin
            total_q     <= total_d;
            sweep_cnt_q <= sweep_cnt_d;
            last_q      <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: a sweep-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_lif_neuron_array;

    localparam int N      = 4;
    localparam int LEAK   = 4;
    localparam int REFRAC = 2;
    localparam int PMAX   = 32767;
    localparam int PMIN   = -32768;

    logic               clk;
    logic               rst;
    logic               en;
    logic signed [15:0] threshold;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_idx;
    logic signed [15:0] in_weight;
    logic               tick;
    logic               busy;
    logic               spk_valid;
    logic [1:0]         spk_idx;
    logic               sweep_done;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0]        spike_total;
    logic [2:0]         last_sweep_spikes;
`endif

    lif_neuron_array dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .threshold  (threshold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_weight  (in_weight),
        .tick       (tick),
        .busy       (busy),
        .spk_valid  (spk_valid),
        .spk_idx    (spk_idx),
        .sweep_done (sweep_done)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_total       (spike_total),
        .last_sweep_spikes (last_sweep_spikes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-sweep results are computed at the tick, then replayed
    // one neuron per enabled clock on the outputs.
    int m_pot [N];
    int m_ref [N];
    bit m_fire [N];
    bit m_busy;
    int m_pos;
    bit m_ov;
    bit m_od;
    int m_oidx;
    int m_total;
    int m_last;
    int m_sweep_spk;

    function automatic int clamp(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    task automatic run_sweep(input int thr);
        m_sweep_spk = 0;
        for (int i = 0; i < N; i++) begin
            m_fire[i] = 1'b0;
            if (m_ref[i] != 0) begin
                m_ref[i] = m_ref[i] - 1;
                m_pot[i] = 0;
            end else if (m_pot[i] >= thr) begin
                m_fire[i] = 1'b1;
                m_pot[i]  = 0;
                m_ref[i]  = REFRAC;
                m_sweep_spk++;
            end else begin
                m_pot[i] = m_pot[i] - (m_pot[i] >>> LEAK);
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pot[i] = 0;
                m_ref[i] = 0;
                m_fire[i] = 1'b0;
            end
            m_busy = 1'b0; m_pos = 0; m_ov = 1'b0; m_od = 1'b0; m_oidx = 0;
            m_total = 0; m_last = 0; m_sweep_spk = 0;
        end else if (en) begin
            if (!m_busy) begin
                m_ov = 1'b0;
                m_od = 1'b0;
                if (in_valid && int'(in_idx) < N && m_ref[in_idx] == 0) begin
                    m_pot[in_idx] = clamp(m_pot[in_idx] + int'(in_weight));
                end
                if (tick) begin
                    run_sweep(int'(threshold));
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
                m_ov = m_fire[m_pos-1];
                if (m_ov) begin
                    m_oidx  = m_pos - 1;
                    m_total = (m_total < 65535) ? m_total + 1 : 65535;
                end
                m_od = (m_pos == N);
                if (m_od) begin
                    m_busy = 1'b0;
                    m_last = m_sweep_spk;
                end
            end
        end
    endtask

    // Single compare process: model advances on each rising edge, outputs checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("spk_valid", spk_valid, en && m_ov);
            check("spk_idx", spk_idx, m_oidx);
            check("sweep_done", sweep_done, en && m_od);
            check("busy", busy, m_busy);
            check("in_ready", in_ready, en && !m_busy);
`ifdef LIF_SPIKE_COUNT_EN
            check("spike_total", spike_total, m_total);
            check("last_sweep_spikes", last_sweep_spikes, m_last);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic send(input int idx, input int w);
        in_valid  = 1'b1;
        in_idx    = 2'(idx);
        in_weight = 16'(w);
        tick      = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Issues a tick, optionally a second tick and an enable gap, and records what the outputs do.
    task automatic tick_watch(input int xtick_at, input int off_at, input int off_len,
                              output int b, output int s, output int d,
                              output int nspk, output int sidx, output int ndone);
        b = -1; s = -1; d = -1; nspk = 0; sidx = -1; ndone = 0;
        tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (busy && b < 0) b = c;
            if (spk_valid) begin
                nspk++;
                if (s < 0) begin
                    s    = c;
                    sidx = int'(spk_idx);
                end
            end
            if (sweep_done) begin
                ndone++;
                if (d < 0) d = c;
            end
            @(negedge clk);
            in_valid = 1'b0;
            tick     = (c + 1 == xtick_at);
            en       = !(c + 1 >= off_at && c + 1 < off_at + off_len);
        end
        tick = 1'b0;
        en   = 1'b1;
    endtask

    int b, s, d, nspk, sidx, ndone;

    initial begin
        rst = 1'b1; en = 1'b1; threshold = '0; in_valid = 1'b0;
        in_idx = '0; in_weight = '0; tick = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) check("reset_pot", dut.pot_q[i], 0);
        rst = 1'b0;
        threshold = 16'sh00F0;
        @(negedge clk);

        // Single fire on neuron 1
        send(1, 16'h0080);
        send(1, 16'h0080);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("fire_count", nspk, 1);
        check("fire_idx", sidx, 1);
        check("fire_latency", s - b, 2);
        check("fire_done_latency", d - b, 4);
        check("fire_pot1", dut.pot_q[1], 0);

        // Leak without firing
        send(0, 16'h00A0);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("leak_count", nspk, 0);
        check("leak_pot0", dut.pot_q[0], 150);
        check("leak_model0", m_pot[0], 150);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("leak2_pot0", dut.pot_q[0], 141);

        // Refractory behaviour on neuron 2
        send(2, 16'h0100);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("refr_fire_count", nspk, 1);
        check("refr_fire_idx", sidx, 2);
        send(2, 16'h0100);
        check("refr_drop_pot2", dut.pot_q[2], 0);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("refr_tick2_count", nspk, 0);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("refr_tick3_count", nspk, 0);
        check("refr_zero", dut.refrac_q[2], 0);
        send(2, 16'h0100);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("refr_refire_count", nspk, 1);
        check("refr_refire_idx", sidx, 2);

        // Saturation at both rails
        send(3, 16'h7FFF);
        send(3, 16'h7FFF);
        check("sat_pos_pot3", dut.pot_q[3], PMAX);
        send(0, 16'h8000);
        send(0, 16'h8000);
        check("sat_neg_pot0", dut.pot_q[0], PMIN);
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("sat_count", nspk, 1);
        check("sat_idx", sidx, 3);
        check("neg_leak_pot0", dut.pot_q[0], -30720);

        // Tick coincident with an event
        in_valid = 1'b1; in_idx = 2'd1; in_weight = 16'sh0100;
        tick_watch(-1, -1, 0, b, s, d, nspk, sidx, ndone);
        check("coinc_count", nspk, 1);
        check("coinc_idx", sidx, 1);

        // Tick during a sweep is dropped
        tick_watch(2, -1, 0, b, s, d, nspk, sidx, ndone);
        check("midtick_done_count", ndone, 1);

        // Enable gap of three cycles mid-sweep
        send(0, 16'h7FFF);
        send(3, 16'h0200);
        tick_watch(-1, 2, 3, b, s, d, nspk, sidx, ndone);
        check("freeze_done_latency", d - b, 7);
        check("freeze_count", nspk, 2);
        check("freeze_first_idx", sidx, 0);

        // Reset in the middle of a sweep
        send(2, 16'h0300);
        send(1, 16'h0300);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) check("midrst_pot", dut.pot_q[i], 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);

        // Random traffic against the model
        for (int k = 0; k < 500; k++) begin
            int w;
            int t;
            en       = ($urandom_range(0, 9) != 0);
            in_valid = $urandom_range(0, 1) != 0;
            in_idx   = 2'($urandom_range(0, N - 1));
            case ($urandom_range(0, 7))
                0: in_weight = 16'sh7FFF;
                1: in_weight = 16'sh8000;
                default: begin
                    w = int'($urandom_range(0, 768)) - 256;
                    in_weight = 16'(w);
                end
            endcase
            tick = ($urandom_range(0, 6) == 0);
            if (!m_busy && $urandom_range(0, 3) == 0) begin
                t = int'($urandom_range(0, 1024)) - 128;
                threshold = 16'(t);
            end
            @(negedge clk);
        end
        en = 1'b1; in_valid = 1'b0; tick = 1'b0;
        repeat (N + 4) @(negedge clk);
        for (int i = 0; i < N; i++) check("end_pot", dut.pot_q[i], m_pot[i]);
        for (int i = 0; i < N; i++) check("end_refrac", dut.refrac_q[i], m_ref[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Time-multiplexed array of N leaky integrate-and-fire neurons sharing one adder/comparator datapath; per-neuron potential and refractory state held in register arrays.
- Accumulates weighted input events during the ACCUM phase. On each `tick`, sweeps all neurons once, applying threshold, fire, leak and refractory, and emits spikes as an index stream.
- Replaces the single-neuron exc/hidden integrate-and-fire blocks in the hidden and output layers.
- Sits between the synapse/weight lookup stage and the next layer's event encoder.

Parameters:
- N_NEURONS, 4, number of neurons in the array (≥2).
- IDX_W, $clog2(N_NEURONS), neuron index width.
- POT_W, 16, signed membrane potential width.
- WGT_W, 16, signed input weight width (≤ POT_W).
- LEAK_SHIFT, 4, leak per tick is pot>>>LEAK_SHIFT; 0 disables leak.
- REFRAC_TICKS, 2, ticks a neuron stays refractory after firing (0 = none).
- REF_W, 8, refractory counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  global enable; low freezes all state
- threshold  in  POT_W  signed firing threshold, sampled at each neuron's evaluation
- in_valid  in  1  input event valid
- in_ready  out  1  high in ACCUM when en=1
- in_idx  in  IDX_W  target neuron
- in_weight  in  WGT_W  signed weight to add
- tick  in  1  single-cycle request to start an update sweep
- busy  out  1  high during SWEEP
- spk_valid  out  1  spike output valid (no backpressure)
- spk_idx  out  IDX_W  index of firing neuron
- sweep_done  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (async):
  - all pot=0, all refrac=0, state=ACCUM.
  - spk_valid=0, spk_idx=0, sweep_done=0, busy=0.
  - Reset mid-sweep aborts the sweep; no further spikes are emitted.
- States: ACCUM, SWEEP.
- ACCUM:
  - Event accepted when in_valid & in_ready.
  - On accept, if refrac[in_idx]==0: pot <= sat(pot + sign_ext(in_weight)), saturating at the POT_W signed max/min. Otherwise the event is dropped.
  - in_idx ≥ N_NEURONS: event accepted and discarded.
- tick in ACCUM with en=1:
  - Transitions to SWEEP next cycle, with sweep pointer i=0.
  - If tick and an accepted event coincide, the event is applied first.
- tick while in SWEEP: ignored, not queued.
- SWEEP: one neuron per cycle, i = 0..N_NEURONS-1.
  - refrac[i]≠0: refrac[i]--, pot[i] held at 0, no spike.
  - else if pot[i] ≥ threshold (signed): spike; pot[i]<=0; refrac[i]<=REFRAC_TICKS.
  - else: pot[i] <= pot[i] - (pot[i]>>>LEAK_SHIFT), or unchanged when LEAK_SHIFT=0. Negative potentials leak toward 0.
- Spike output latency: spk_valid/spk_idx registered one cycle after neuron i is evaluated; at most one spike per cycle.
- Sweep length: exactly N_NEURONS evaluation cycles.
- End of sweep:
  - sweep_done pulses in the cycle after the last evaluation, coincident with the last neuron's spk_valid.
  - The block returns to ACCUM that same cycle; in_ready rises then.
- busy=1 and in_ready=0 for all evaluation cycles.
- en=0:
  - All state, pointers and counters hold.
  - in_ready=0; tick ignored.
  - spk_valid and sweep_done forced 0. An output pending at freeze is emitted when en returns.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined:
  - Adds output spike_total [16] counting spikes emitted since reset, saturating at 0xFFFF.
  - Adds output last_sweep_spikes [IDX_W+1], the spike count of the most recent completed sweep, updated on the sweep_done cycle.
  - Both reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package snn_pkg:
  - state enum {ACCUM, SWEEP}.
  - sat_add function (signed, width-parametrised).
  - default POT_W/WGT_W constants, shared with the weight lookup block.
- One sub-module, lif_update_core: combinational evaluation of one neuron (pot, refrac, threshold → next pot, next refrac, fire).
- The array module owns the state arrays, FSM and output registers.

Test Plan:
- Reset mid-sweep: tick, then rst asserted after 2 evaluation cycles → no spk_valid afterwards; all pot=0; in_ready=1 once rst drops.
- Single fire: N=4, thr=0x00F0, LEAK_SHIFT=0; events (1,0x0080)×2, then tick → exactly one spk_valid with spk_idx=1, 2 cycles after busy rises; sweep_done 4 cycles after busy rises; pot[1]=0.
- Leak and no fire: LEAK_SHIFT=4; event (0,0x00A0), tick → no spike, pot[0]=0x0096. Second tick → 0x008D.
- Refractory: REFRAC_TICKS=2, neuron 2 fires.
  - Event (2,0x0100) during the next ACCUM is dropped.
  - Ticks 2 and 3 give no spike; refrac reaches 0.
  - After that, an event of 0x0100 plus a tick → spike again.
- Saturation and negatives: events (3,0x7FFF),(3,0x7FFF) → pot[3]=0x7FFF. Events (0,0x8000)×2 → pot[0]=0x8000, no spike, and leak moves it toward 0.
- Handshake edges:
  - tick and event in the same cycle → event included in that sweep.
  - tick during SWEEP → ignored (exactly one sweep_done).
  - en=0 for 3 cycles mid-sweep → sweep stretches by 3 cycles; spike order and indices unchanged.
